// File: rtl/mpi_pkg.sv
// ---------------------------------------------------------------------------
// mpi_pkg
// Definitions shared by the MPI bus-responder blocks: the transaction FSM
// state encoding, the active-low bus polarity constants, and the address
// window compare used to decide whether a bus cycle belongs to this target.
// ---------------------------------------------------------------------------
package mpi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,  // waiting for an address strobe
        ST_IGNORE  = 3'd1,  // cycle addressed elsewhere, stay silent
        ST_ADDR    = 3'd2,  // selected, waiting for DIN or DOUT
        ST_RD_WAIT = 3'd3,  // read wait states, data presented at count 0
        ST_RD_RPLY = 3'd4,  // read reply asserted, waiting for DIN release
        ST_WR_WAIT = 3'd5,  // write wait states, commit at count 0
        ST_WR_RPLY = 3'd6   // write reply asserted, waiting for DOUT release
    } state_t;

    // The bus is inverted on the pins: 0 means asserted.
    localparam logic        ASSERTED_N    = 1'b0;
    localparam logic        NEGATED_N     = 1'b1;
    localparam logic [15:0] AD_RELEASED_N = 16'hFFFF;

    // True when addr falls in the 2^(aw+1)-byte window that starts at base.
    // Only the bits above the window size take part in the compare.
    function automatic logic window_hit(input logic [15:0] addr,
                                        input logic [15:0] base,
                                        input int unsigned aw);
        return (addr >> (aw + 1)) == (base >> (aw + 1));
    endfunction

endpackage

// File: rtl/mpi_strobe_sync.sv
// ---------------------------------------------------------------------------
// mpi_strobe_sync
// Brings one asynchronous active-low bus strobe into the clock domain and
// flags its falling (assertion) edge.
//   clk       in   block clock
//   rst_n     in   asynchronous active-low reset, chain resets to 1 (idle)
//   strobe_n  in   raw strobe from the pin
//   level     out  synchronized strobe level
//   fall      out  one-clock pulse on the synchronized 1->0 transition
// The release of a strobe is taken from the synchronized level rather than a
// rising-edge pulse, so a release that lands in a state not watching for it
// is still seen later.
// ---------------------------------------------------------------------------
module mpi_strobe_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_n,
    output logic level,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              last;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchronizer chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
            last  <= 1'b1;
        end else begin
            chain <= {chain[STAGES-2:0], strobe_n};
            last  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign fall  = last & ~chain[STAGES-1];

endmodule

// File: rtl/mpi_slave_ram.sv
// ---------------------------------------------------------------------------
// mpi_slave_ram
// Word-addressed RAM target on the MPI (Q-bus-style) bus. Decodes the
// inverted address latched on SYNC against a base window and answers DIN
// reads, DOUT word/byte writes and read-modify-write cycles with RPLY after
// a programmable number of wait states.
//   pin_clk       in   block clock, rising edge
//   pin_init_n    in   asynchronous active-low reset
//   pin_ad_in_n   in   inverted AD bus from the pins
//   pin_ad_out_n  out  inverted read data (FFFF when not driving)
//   pin_ad_oe     out  1 = drive pin_ad_out_n onto AD
//   pin_sync_n    in   address strobe, active low
//   pin_din_n     in   read data strobe, active low
//   pin_dout_n    in   write data strobe, active low
//   pin_wtbt_n    in   low in data phase = byte write
//   pin_rply_n    out  transaction reply, active low
//   sel_hit       out  debug: current bus cycle is addressed to this block
// Strobe pin edge to RPLY low: SYNC_STAGES + 1 + WAIT + 1 clocks.
// ---------------------------------------------------------------------------
module mpi_slave_ram
    import mpi_pkg::*;
#(
    parameter logic [15:0] BASE        = 16'h0000,
    parameter int          AW          = 12,
    parameter int          WAIT        = 2,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        pin_clk,
    input  logic        pin_init_n,
    input  logic [15:0] pin_ad_in_n,
    output logic [15:0] pin_ad_out_n,
    output logic        pin_ad_oe,
    input  logic        pin_sync_n,
    input  logic        pin_din_n,
    input  logic        pin_dout_n,
    input  logic        pin_wtbt_n,
    output logic        pin_rply_n,
    output logic        sel_hit
);

    // ---------------------------------------------------------------------
    // Strobe synchronizers
    // ---------------------------------------------------------------------
    logic sync_lvl, sync_fall;
    logic din_lvl,  din_fall;
    logic dout_lvl, dout_fall;

    mpi_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_sync (
        .clk      (pin_clk),
        .rst_n    (pin_init_n),
        .strobe_n (pin_sync_n),
        .level    (sync_lvl),
        .fall     (sync_fall)
    );

    mpi_strobe_sync #(.STAGES(SYNC_STAGES)) u_din_sync (
        .clk      (pin_clk),
        .rst_n    (pin_init_n),
        .strobe_n (pin_din_n),
        .level    (din_lvl),
        .fall     (din_fall)
    );

    mpi_strobe_sync #(.STAGES(SYNC_STAGES)) u_dout_sync (
        .clk      (pin_clk),
        .rst_n    (pin_init_n),
        .strobe_n (pin_dout_n),
        .level    (dout_lvl),
        .fall     (dout_fall)
    );

    // ---------------------------------------------------------------------
    // Registered state
    // ---------------------------------------------------------------------
    state_t        state_q,    state_d;
    logic [3:0]    cnt_q,      cnt_d;
    logic [AW:0]   addr_q,     addr_d;      // byte address within window
    logic [15:0]   wdata_q,    wdata_d;
    logic          byte_q,     byte_d;
    logic          rply_n_q,   rply_n_d;
    logic          ad_oe_q,    ad_oe_d;
    logic [15:0]   ad_out_n_q, ad_out_n_d;
    logic          sel_hit_q,  sel_hit_d;

    logic          mem_we;
    logic [15:0]   ad_addr;
    logic [AW-1:0] word_idx;

    logic [15:0]   mem [0:(1 << AW) - 1];

    assign ad_addr  = ~pin_ad_in_n;
    assign word_idx = addr_q[AW:1];

    always_ff @(posedge pin_clk or negedge pin_init_n) begin
        if (!pin_init_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            byte_q     <= 1'b0;
            rply_n_q   <= NEGATED_N;
            ad_oe_q    <= 1'b0;
            ad_out_n_q <= AD_RELEASED_N;
            sel_hit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            byte_q     <= byte_d;
            rply_n_q   <= rply_n_d;
            ad_oe_q    <= ad_oe_d;
            ad_out_n_q <= ad_out_n_d;
            sel_hit_q  <= sel_hit_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and output logic
    // ---------------------------------------------------------------------
    // NOTE: every signal assigned below gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        byte_d     = byte_q;
        rply_n_d   = rply_n_q;
        ad_oe_d    = ad_oe_q;
        ad_out_n_d = ad_out_n_q;
        mem_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sync_fall) begin
                    addr_d  = ad_addr[AW:0];
                    state_d = window_hit(ad_addr, BASE, AW) ? ST_ADDR : ST_IGNORE;
                end
            end

            ST_IGNORE: begin
                if (sync_lvl) state_d = ST_IDLE;
            end

            ST_ADDR: begin
                // DIN has priority if both data strobes arrive together.
                if (din_fall) begin
                    state_d = ST_RD_WAIT;
                    cnt_d   = 4'(WAIT);
                end else if (dout_fall) begin
                    state_d = ST_WR_WAIT;
                    cnt_d   = 4'(WAIT);
                    wdata_d = ad_addr;
                    byte_d  = ~pin_wtbt_n;
                end
            end

            ST_RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = ST_RD_RPLY;
                    rply_n_d = ASSERTED_N;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_RD_RPLY: begin
                if (din_lvl) begin
                    state_d    = ST_ADDR;
                    rply_n_d   = NEGATED_N;
                    ad_oe_d    = 1'b0;
                    ad_out_n_d = AD_RELEASED_N;
                end
            end

            ST_WR_WAIT: begin
                if (cnt_q == 4'd0) begin
                    mem_we   = 1'b1;
                    state_d  = ST_WR_RPLY;
                    rply_n_d = ASSERTED_N;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_WR_RPLY: begin
                if (dout_lvl) begin
                    state_d  = ST_ADDR;
                    rply_n_d = NEGATED_N;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // SYNC released mid-cycle: drop everything, including an uncommitted
        // write on this same clock.
        if (state_q != ST_IDLE && sync_lvl) begin
            state_d    = ST_IDLE;
            rply_n_d   = NEGATED_N;
            ad_oe_d    = 1'b0;
            ad_out_n_d = AD_RELEASED_N;
            mem_we     = 1'b0;
        end

        // Read data goes onto the bus on the clock that enters wait count 0,
        // so it is stable for a full clock before RPLY asserts.
        if (state_d == ST_RD_WAIT && cnt_d == 4'd0) begin
            ad_oe_d    = 1'b1;
            ad_out_n_d = ~mem[word_idx];
        end

        sel_hit_d = (state_d != ST_IDLE) && (state_d != ST_IGNORE);
    end

    // ---------------------------------------------------------------------
    // RAM array, byte-lane writes selected by address bit 0
    // ---------------------------------------------------------------------
    // NOTE: the array has no reset; contents survive pin_init_n and a reset
    // branch here would prevent block-RAM inference.
    always_ff @(posedge pin_clk) begin
        if (mem_we) begin
            if (!byte_q)
                mem[word_idx] <= wdata_q;
            else if (addr_q[0])
                mem[word_idx][15:8] <= wdata_q[15:8];
            else
                mem[word_idx][7:0] <= wdata_q[7:0];
        end
    end

    assign pin_rply_n   = rply_n_q;
    assign pin_ad_oe    = ad_oe_q;
    assign pin_ad_out_n = ad_out_n_q;
    assign sel_hit      = sel_hit_q;

endmodule

// File: tb/tb_mpi_slave_ram.sv
// ---------------------------------------------------------------------------
// tb_mpi_slave_ram
// Directed bench for mpi_slave_ram with BASE=0, AW=12, WAIT=2, SYNC_STAGES=2.
// Inputs change on the falling clock edge; outputs are sampled 1ns after the
// rising edge. Expected RPLY latency counts rising edges from the strobe
// change: SYNC_STAGES + 1 + WAIT + 1 = 6.
// ---------------------------------------------------------------------------
module tb_mpi_slave_ram;

    localparam logic [15:0] BASE        = 16'h0000;
    localparam int          AW          = 12;
    localparam int          WAIT        = 2;
    localparam int          SYNC_STAGES = 2;
    localparam int          LAT         = SYNC_STAGES + 1 + WAIT + 1;

    logic        clk = 1'b0;
    logic        init_n;
    logic [15:0] ad_in_n;
    logic [15:0] ad_out_n;
    logic        ad_oe;
    logic        sync_n, din_n, dout_n, wtbt_n;
    logic        rply_n;
    logic        hit;

    int checks = 0;
    int errors = 0;

    mpi_slave_ram #(
        .BASE        (BASE),
        .AW          (AW),
        .WAIT        (WAIT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .pin_clk      (clk),
        .pin_init_n   (init_n),
        .pin_ad_in_n  (ad_in_n),
        .pin_ad_out_n (ad_out_n),
        .pin_ad_oe    (ad_oe),
        .pin_sync_n   (sync_n),
        .pin_din_n    (din_n),
        .pin_dout_n   (dout_n),
        .pin_wtbt_n   (wtbt_n),
        .pin_rply_n   (rply_n),
        .sel_hit      (hit)
    );

    always #5 clk = ~clk;

    // ---------------- bus phase helpers (no comparisons inside) ------------
    task automatic addr_phase(input logic [15:0] a, input logic wr);
        @(negedge clk);
        ad_in_n = ~a;
        wtbt_n  = ~wr;
        sync_n  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_cycle();
        sync_n  = 1'b1;
        din_n   = 1'b1;
        dout_n  = 1'b1;
        ad_in_n = 16'hFFFF;
        wtbt_n  = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic data_write(input logic [15:0] d, input logic bw,
                              output int lat, output logic released);
        ad_in_n = ~d;
        wtbt_n  = ~bw;
        dout_n  = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (rply_n === 1'b0) begin lat = i; break; end
        end
        @(negedge clk);
        dout_n  = 1'b1;
        ad_in_n = 16'hFFFF;
        wtbt_n  = 1'b1;
        released = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rply_n === 1'b1) begin released = 1'b1; break; end
        end
        @(negedge clk);
    endtask

    task automatic data_read(output int lat, output logic [15:0] d_rply,
                             output logic oe_before, output logic [15:0] d_before,
                             output logic released, output logic oe_after,
                             output logic [15:0] d_after);
        logic        p_oe;
        logic [15:0] p_d;
        p_oe = 1'b0;
        p_d  = 16'hFFFF;
        lat = -1; d_rply = 'x; oe_before = 1'b0; d_before = 'x;
        din_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (rply_n === 1'b0) begin
                lat = i; d_rply = ad_out_n; oe_before = p_oe; d_before = p_d;
                break;
            end
            p_oe = ad_oe;
            p_d  = ad_out_n;
        end
        @(negedge clk);
        din_n = 1'b1;
        released = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rply_n === 1'b1) begin released = 1'b1; break; end
        end
        oe_after = ad_oe;
        d_after  = ad_out_n;
        @(negedge clk);
    endtask

    // Full single-SYNC read, returns the inverted data seen at RPLY.
    task automatic simple_read(input logic [15:0] a, output int lat,
                               output logic [15:0] d_rply);
        logic        oe_b, rel, oe_a;
        logic [15:0] d_b, d_a;
        addr_phase(a, 1'b0);
        data_read(lat, d_rply, oe_b, d_b, rel, oe_a, d_a);
        end_cycle();
    endtask

    task automatic simple_write(input logic [15:0] a, input logic [15:0] d,
                                input logic bw, output int lat);
        logic rel;
        addr_phase(a, 1'b1);
        data_write(d, bw, lat, rel);
        end_cycle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        init_n = 1'b0; sync_n = 1'b1; din_n = 1'b1; dout_n = 1'b1;
        wtbt_n = 1'b1; ad_in_n = 16'hFFFF;
        repeat (3) @(posedge clk); #1;
        checks++; if (rply_n !== 1'b1) begin errors++; $display("FAIL reset_rply: got %b want 1", rply_n); end
        checks++; if (ad_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", ad_oe); end
        checks++; if (ad_out_n !== 16'hFFFF) begin errors++; $display("FAIL reset_ad_out: got %h want ffff", ad_out_n); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_sel_hit: got %b want 0", hit); end
        @(negedge clk); init_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_word_write_read();
        int          lat;
        logic        rel, oe_b, oe_a;
        logic [15:0] d_r, d_b, d_a;
        addr_phase(16'o001000, 1'b1);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL ww_sel_hit: got %b want 1", hit); end
        data_write(16'h1234, 1'b0, lat, rel);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL ww_latency: got %0d want %0d", lat, LAT); end
        checks++; if (rel !== 1'b1) begin errors++; $display("FAIL ww_rply_release: got %b want 1", rel); end
        end_cycle();
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL ww_sel_hit_end: got %b want 0", hit); end

        addr_phase(16'o001000, 1'b0);
        data_read(lat, d_r, oe_b, d_b, rel, oe_a, d_a);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL wr_latency: got %0d want %0d", lat, LAT); end
        checks++; if (d_r !== 16'hEDCB) begin errors++; $display("FAIL wr_data: got %h want edcb", d_r); end
        checks++; if (oe_b !== 1'b1) begin errors++; $display("FAIL wr_oe_lead: got %b want 1", oe_b); end
        checks++; if (d_b !== 16'hEDCB) begin errors++; $display("FAIL wr_data_lead: got %h want edcb", d_b); end
        checks++; if (rel !== 1'b1) begin errors++; $display("FAIL wr_rply_release: got %b want 1", rel); end
        checks++; if ({oe_a, d_a} !== {1'b0, 16'hFFFF}) begin errors++; $display("FAIL wr_bus_release: got oe=%b ad=%h want oe=0 ad=ffff", oe_a, d_a); end
        end_cycle();
    endtask

    task automatic test_byte_write();
        int          lat;
        logic [15:0] d_r;
        simple_write(16'o002000, 16'hFFFF, 1'b0, lat);
        simple_write(16'o002001, 16'hA500, 1'b1, lat);
        simple_read(16'o002000, lat, d_r);
        checks++; if (d_r !== ~16'hA5FF) begin errors++; $display("FAIL byte_high: got %h want %h", d_r, ~16'hA5FF); end
        simple_write(16'o002000, 16'h005A, 1'b1, lat);
        simple_read(16'o002001, lat, d_r);
        checks++; if (d_r !== ~16'hA55A) begin errors++; $display("FAIL byte_low: got %h want %h", d_r, ~16'hA55A); end
    endtask

    task automatic test_miss();
        logic bad;
        bad = 1'b0;
        addr_phase(16'o020000, 1'b0);
        din_n = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (rply_n !== 1'b1 || ad_oe !== 1'b0 || hit !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL miss_silent: got violation=%b want 0", bad); end
        @(negedge clk);
        end_cycle();
    endtask

    task automatic test_rmw();
        int          lat;
        logic        rel, oe_b, oe_a;
        logic [15:0] d_r, d_b, d_a;
        simple_write(16'o003000, 16'h1234, 1'b0, lat);
        addr_phase(16'o003000, 1'b1);
        data_read(lat, d_r, oe_b, d_b, rel, oe_a, d_a);
        checks++; if (d_r !== 16'hEDCB) begin errors++; $display("FAIL rmw_read: got %h want edcb", d_r); end
        checks++; if (rel !== 1'b1) begin errors++; $display("FAIL rmw_read_release: got %b want 1", rel); end
        data_write(16'h4321, 1'b0, lat, rel);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL rmw_write_latency: got %0d want %0d", lat, LAT); end
        end_cycle();
        simple_read(16'o003000, lat, d_r);
        checks++; if (d_r !== ~16'h4321) begin errors++; $display("FAIL rmw_result: got %h want %h", d_r, ~16'h4321); end
    endtask

    task automatic test_abort();
        int          lat;
        logic        bad;
        logic [15:0] d_r;
        // SYNC released while the read is still counting wait states.
        addr_phase(16'o001000, 1'b0);
        din_n = 1'b0;
        @(posedge clk); @(negedge clk);
        sync_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rply_n !== 1'b1 || ad_oe !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL abort_read_silent: got violation=%b want 0", bad); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL abort_idle: got sel_hit=%b want 0", hit); end
        @(negedge clk);
        end_cycle();
        simple_read(16'o001000, lat, d_r);
        checks++; if ({lat, d_r} !== {LAT, 16'hEDCB}) begin errors++; $display("FAIL abort_recover: got lat=%0d d=%h want lat=%0d d=edcb", lat, d_r, LAT); end

        // Reset while RPLY is asserted on a read.
        addr_phase(16'o001000, 1'b0);
        din_n = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (rply_n === 1'b0) begin lat = i; break; end
        end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL rst_pre_rply: got %0d want %0d", lat, LAT); end
        #2 init_n = 1'b0;
        #1;
        checks++; if ({rply_n, ad_oe, ad_out_n} !== {1'b1, 1'b0, 16'hFFFF}) begin
            errors++; $display("FAIL rst_async_release: got rply=%b oe=%b ad=%h want 1 0 ffff", rply_n, ad_oe, ad_out_n); end
        @(negedge clk);
        end_cycle();
        init_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset during write wait states drops the pending write.
        addr_phase(16'o001000, 1'b1);
        ad_in_n = ~16'h5555;
        dout_n  = 1'b0;
        repeat (4) @(posedge clk);
        #2 init_n = 1'b0;
        #1;
        checks++; if (rply_n !== 1'b1) begin errors++; $display("FAIL rst_write_rply: got %b want 1", rply_n); end
        @(negedge clk);
        end_cycle();
        init_n = 1'b1;
        repeat (2) @(negedge clk);
        simple_read(16'o001000, lat, d_r);
        checks++; if (d_r !== 16'hEDCB) begin errors++; $display("FAIL rst_write_dropped: got %h want edcb", d_r); end
    endtask

    initial begin
        test_reset();
        test_word_write_read();
        test_byte_write();
        test_miss();
        test_rmw();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
